mod12_seq_checker: RTL and testbench

Passive sequence checker on the observation side of a mod-12 up/down counter with load. Each cycle it samples the counter's controls (load, mode, datain) and its count output, predicts the next count from the previous sample, and flags mismatches, out-of-range values and wrap events. It sits beside the counter in integration or bench wiring, drives nothing back into it, and reports through pulse flags, a saturating error counter and a lock/fault state.

---
 rtl/mod12_pkg.sv | 11 +
 rtl/mod12_seq_checker_if.sv | 10 +
 rtl/mod12_next_model.sv | 12 +
 rtl/mod12_seq_checker.sv | 82 ++++++++
 tb/tb_mod12_seq_checker.sv | 119 +++++++++++
 5 files changed

// File: rtl/mod12_pkg.sv
// mod12_pkg: shared constants, checker states and the mod-12 next-count function
package mod12_pkg;
  localparam logic [3:0] MOD_N = 4'd12;
  localparam logic [3:0] CNT_MAX = 4'd11;
  typedef enum logic [1:0] {UNSYNC, TRACK, FAULT} state_t;
  function automatic logic [3:0] next_count(input logic [3:0] count, input logic load, input logic mode, input logic [3:0] datain);
    if (load && datain < MOD_N) return datain;
    if (mode) return count == CNT_MAX ? 4'd0 : count + 4'd1;
    return count == 4'd0 ? CNT_MAX : count - 4'd1;
  endfunction
endpackage

// File: rtl/mod12_seq_checker_if.sv
// mod12_seq_checker_if: observed counter sample bus (valid, load, mode, datain, count); master drives, slave observes
interface mod12_seq_checker_if;
  logic obs_valid;
  logic obs_load;
  logic obs_mode;
  logic [3:0] obs_datain;
  logic [3:0] obs_count;
  modport master (output obs_valid, obs_load, obs_mode, obs_datain, obs_count);
  modport slave (input obs_valid, obs_load, obs_mode, obs_datain, obs_count);
endinterface

// File: rtl/mod12_next_model.sv
// mod12_next_model: combinational next-count prediction (count, load, mode, datain -> nxt)
module mod12_next_model
  import mod12_pkg::*;
(
  input  logic [3:0] count,
  input  logic       load,
  input  logic       mode,
  input  logic [3:0] datain,
  output logic [3:0] nxt
);
  always_comb nxt = next_count(count, load, mode, datain);
endmodule

// File: rtl/mod12_seq_checker.sv
// mod12_seq_checker: passive mod-12 counter checker; clk/rst/clr + obs bus in, err/illegal/wrap pulses, exp_count, err_count, locked, fault out
module mod12_seq_checker
  import mod12_pkg::*;
#(
  parameter int ERR_W = 8,
  parameter int FAULT_LIMIT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  mod12_seq_checker_if.slave obs,
  output logic             err,
  output logic             illegal,
  output logic             wrap_up,
  output logic             wrap_dn,
  output logic [3:0]       exp_count,
  output logic [ERR_W-1:0] err_count,
  output logic             locked,
  output logic             fault
);
  state_t state;
  logic [3:0] count_p, datain_p, pred, consec;
  logic load_p, mode_p, bl_vld, load_hit, mis;
  mod12_next_model u_next (.count(count_p), .load(load_p), .mode(mode_p), .datain(datain_p), .nxt(pred));
  always_comb begin
    load_hit = load_p && datain_p < MOD_N;
    mis = obs.obs_count != pred;
    locked = state == TRACK;
    fault = state == FAULT;
  end
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state <= UNSYNC;
      bl_vld <= 1'b0;
      consec <= '0;
      err_count <= '0;
      err <= 1'b0;
      illegal <= 1'b0;
      wrap_up <= 1'b0;
      wrap_dn <= 1'b0;
      exp_count <= '0;
      count_p <= '0;
      load_p <= 1'b0;
      mode_p <= 1'b0;
      datain_p <= '0;
    end else begin
      err <= 1'b0;
      illegal <= 1'b0;
      wrap_up <= 1'b0;
      wrap_dn <= 1'b0;
      if (obs.obs_valid) begin
        illegal <= obs.obs_count >= MOD_N;
        count_p <= obs.obs_count;
        load_p <= obs.obs_load;
        mode_p <= obs.obs_mode;
        datain_p <= obs.obs_datain;
        bl_vld <= 1'b1;
        if (state == UNSYNC) state <= TRACK;
        else if (bl_vld) begin
          exp_count <= pred;
          if (mis) begin
            err <= 1'b1;
            if (err_count != '1) err_count <= err_count + ERR_W'(1);
            if (consec != 4'hf) consec <= consec + 4'd1;
            if (state == TRACK && consec + 4'd1 >= 4'(FAULT_LIMIT)) state <= FAULT;
          end else begin
            consec <= '0;
            wrap_up <= !load_hit && mode_p && count_p == CNT_MAX;
            wrap_dn <= !load_hit && !mode_p && count_p == 4'd0;
          end
        end
      end else begin
        // a gap invalidates the baseline; FAULT stays sticky, TRACK falls back to UNSYNC
        bl_vld <= 1'b0;
        if (state == TRACK) begin
          state <= UNSYNC;
          consec <= '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_mod12_seq_checker.sv
// tb_mod12_seq_checker: table-driven scoreboard bench for mod12_seq_checker
module tb_mod12_seq_checker;
  typedef struct {
    logic rst, clr, val, ld, md;
    logic [3:0] din, cnt;
    logic err, ill, wu, wd;
    logic [3:0] ex;
    int ec;
    logic lk, ft;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr = 1'b0;
  logic err, illegal, wrap_up, wrap_dn, locked, fault;
  logic [3:0] exp_count;
  logic [7:0] err_count;
  int n_cmp = 0;
  int n_bad = 0;
  int row = 0;
  vec_t tbl[$];
  vec_t exp_q[$];
  mod12_seq_checker_if ifc ();
  mod12_seq_checker #(.ERR_W(8), .FAULT_LIMIT(3)) dut (
    .clk(clk), .rst(rst), .clr(clr), .obs(ifc),
    .err(err), .illegal(illegal), .wrap_up(wrap_up), .wrap_dn(wrap_dn),
    .exp_count(exp_count), .err_count(err_count), .locked(locked), .fault(fault)
  );
  always #5 clk = ~clk;
  function automatic vec_t v(logic r, logic c, logic va, logic l, logic m, logic [3:0] d, logic [3:0] n,
                             logic e, logic i, logic u, logic w, logic [3:0] x, int ec, logic k, logic f);
    vec_t t;
    t.rst = r; t.clr = c; t.val = va; t.ld = l; t.md = m; t.din = d; t.cnt = n;
    t.err = e; t.ill = i; t.wu = u; t.wd = w; t.ex = x; t.ec = ec; t.lk = k; t.ft = f;
    return t;
  endfunction
  task automatic chk(string name, int act, int want);
    n_cmp++;
    if (act != want) begin
      n_bad++;
      $display("FAIL row %0d %s: got %0d want %0d", row, name, act, want);
    end
  endtask
  task automatic apply(vec_t t);
    vec_t e;
    @(negedge clk);
    rst = t.rst; clr = t.clr;
    ifc.obs_valid = t.val; ifc.obs_load = t.ld; ifc.obs_mode = t.md;
    ifc.obs_datain = t.din; ifc.obs_count = t.cnt;
    exp_q.push_back(t);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("err", int'(err), int'(e.err));
    chk("illegal", int'(illegal), int'(e.ill));
    chk("wrap_up", int'(wrap_up), int'(e.wu));
    chk("wrap_dn", int'(wrap_dn), int'(e.wd));
    chk("exp_count", int'(exp_count), int'(e.ex));
    chk("err_count", int'(err_count), e.ec);
    chk("locked", int'(locked), int'(e.lk));
    chk("fault", int'(fault), int'(e.ft));
    row++;
  endtask
  initial begin
    ifc.obs_valid = 1'b0; ifc.obs_load = 1'b0; ifc.obs_mode = 1'b0;
    ifc.obs_datain = 4'd0; ifc.obs_count = 4'd0;
    //                 rst clr val ld md din  cnt   err ill wu wd exp ec lk ft
    tbl.push_back(v(1, 0, 0, 0, 0, 4'd0, 4'd0,   0, 0, 0, 0, 4'd0, 0, 0, 0));
    tbl.push_back(v(0, 0, 1, 0, 1, 4'd0, 4'd0,   0, 0, 0, 0, 4'd0, 0, 1, 0));
    tbl.push_back(v(0, 0, 1, 0, 1, 4'd0, 4'd1,   0, 0, 0, 0, 4'd1, 0, 1, 0));
    tbl.push_back(v(0, 0, 1, 0, 1, 4'd0, 4'd2,   0, 0, 0, 0, 4'd2, 0, 1, 0));
    tbl.push_back(v(0, 1, 1, 0, 1, 4'd0, 4'd10,  0, 0, 0, 0, 4'd0, 0, 0, 0));
    tbl.push_back(v(0, 0, 1, 0, 1, 4'd0, 4'd10,  0, 0, 0, 0, 4'd0, 0, 1, 0));
    tbl.push_back(v(0, 0, 1, 0, 1, 4'd0, 4'd11,  0, 0, 0, 0, 4'd11, 0, 1, 0));
    tbl.push_back(v(0, 0, 1, 0, 1, 4'd0, 4'd0,   0, 0, 1, 0, 4'd0, 0, 1, 0));
    tbl.push_back(v(0, 0, 1, 0, 0, 4'd0, 4'd1,   0, 0, 0, 0, 4'd1, 0, 1, 0));
    tbl.push_back(v(0, 0, 1, 0, 0, 4'd0, 4'd0,   0, 0, 0, 0, 4'd0, 0, 1, 0));
    tbl.push_back(v(0, 0, 1, 0, 0, 4'd0, 4'd11,  0, 0, 0, 1, 4'd11, 0, 1, 0));
    tbl.push_back(v(0, 0, 1, 1, 0, 4'd5, 4'd10,  0, 0, 0, 0, 4'd10, 0, 1, 0));
    tbl.push_back(v(0, 0, 1, 1, 0, 4'd9, 4'd5,   0, 0, 0, 0, 4'd5, 0, 1, 0));
    tbl.push_back(v(0, 0, 1, 0, 1, 4'd0, 4'd9,   0, 0, 0, 0, 4'd9, 0, 1, 0));
    tbl.push_back(v(0, 0, 1, 1, 1, 4'd5, 4'd10,  0, 0, 0, 0, 4'd10, 0, 1, 0));
    tbl.push_back(v(0, 0, 1, 1, 1, 4'd13, 4'd5,  0, 0, 0, 0, 4'd5, 0, 1, 0));
    tbl.push_back(v(0, 0, 1, 0, 1, 4'd0, 4'd13,  1, 1, 0, 0, 4'd6, 1, 1, 0));
    tbl.push_back(v(0, 0, 1, 0, 1, 4'd0, 4'd0,   1, 0, 0, 0, 4'd14, 2, 1, 0));
    tbl.push_back(v(0, 0, 1, 0, 1, 4'd0, 4'd0,   1, 0, 0, 0, 4'd1, 3, 0, 1));
    tbl.push_back(v(0, 0, 1, 0, 1, 4'd0, 4'd1,   0, 0, 0, 0, 4'd1, 3, 0, 1));
    tbl.push_back(v(0, 1, 1, 0, 1, 4'd0, 4'd5,   0, 0, 0, 0, 4'd0, 0, 0, 0));
    tbl.push_back(v(0, 0, 1, 0, 1, 4'd0, 4'd2,   0, 0, 0, 0, 4'd0, 0, 1, 0));
    tbl.push_back(v(0, 0, 1, 0, 1, 4'd0, 4'd3,   0, 0, 0, 0, 4'd3, 0, 1, 0));
    tbl.push_back(v(0, 0, 0, 0, 1, 4'd0, 4'd4,   0, 0, 0, 0, 4'd3, 0, 0, 0));
    tbl.push_back(v(0, 0, 1, 0, 1, 4'd0, 4'd7,   0, 0, 0, 0, 4'd3, 0, 1, 0));
    tbl.push_back(v(0, 0, 1, 0, 1, 4'd0, 4'd8,   0, 0, 0, 0, 4'd8, 0, 1, 0));
    tbl.push_back(v(0, 0, 1, 0, 1, 4'd0, 4'd0,   1, 0, 0, 0, 4'd9, 1, 1, 0));
    tbl.push_back(v(0, 0, 1, 0, 1, 4'd0, 4'd1,   0, 0, 0, 0, 4'd1, 1, 1, 0));
    tbl.push_back(v(0, 0, 1, 0, 1, 4'd0, 4'd5,   1, 0, 0, 0, 4'd2, 2, 1, 0));
    tbl.push_back(v(0, 0, 1, 0, 1, 4'd0, 4'd6,   0, 0, 0, 0, 4'd6, 2, 1, 0));
    tbl.push_back(v(0, 0, 1, 0, 1, 4'd0, 4'd0,   1, 0, 0, 0, 4'd7, 3, 1, 0));
    tbl.push_back(v(0, 0, 1, 0, 1, 4'd0, 4'd1,   0, 0, 0, 0, 4'd1, 3, 1, 0));
    tbl.push_back(v(0, 0, 1, 0, 1, 4'd0, 4'd9,   1, 0, 0, 0, 4'd2, 4, 1, 0));
    tbl.push_back(v(1, 1, 1, 0, 1, 4'd0, 4'd5,   0, 0, 0, 0, 4'd0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 1, 4'd0, 4'd6,   0, 0, 0, 0, 4'd0, 0, 0, 0));
    tbl.push_back(v(0, 0, 1, 0, 0, 4'd0, 4'd14,  0, 1, 0, 0, 4'd0, 0, 1, 0));
    tbl.push_back(v(0, 0, 1, 0, 0, 4'd0, 4'd13,  0, 1, 0, 0, 4'd13, 0, 1, 0));
    tbl.push_back(v(0, 0, 1, 0, 0, 4'd0, 4'd12,  0, 1, 0, 0, 4'd12, 0, 1, 0));
    tbl.push_back(v(0, 0, 1, 0, 0, 4'd0, 4'd11,  0, 0, 0, 0, 4'd11, 0, 1, 0));
    foreach (tbl[i]) apply(tbl[i]);
    // stuck counter in FAULT: err keeps pulsing while err_count saturates at 255
    apply(v(0, 1, 0, 0, 1, 4'd0, 4'd0, 0, 0, 0, 0, 4'd0, 0, 0, 0));
    apply(v(0, 0, 1, 0, 1, 4'd0, 4'd0, 0, 0, 0, 0, 4'd0, 0, 1, 0));
    for (int i = 1; i <= 300; i++)
      apply(v(0, 0, 1, 0, 1, 4'd0, 4'd0, 1, 0, 0, 0, 4'd1, i > 255 ? 255 : i, i < 3, i >= 3));
    // a gap in FAULT keeps fault; the next sample is a baseline only
    apply(v(0, 0, 0, 0, 1, 4'd0, 4'd0, 0, 0, 0, 0, 4'd1, 255, 0, 1));
    apply(v(0, 0, 1, 0, 1, 4'd0, 4'd15, 0, 1, 0, 0, 4'd1, 255, 0, 1));
    apply(v(0, 0, 1, 0, 1, 4'd0, 4'd0, 0, 0, 0, 0, 4'd0, 255, 0, 1));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
